// File: rtl/chan_scan_seq.sv
// rtl/chan_scan_seq.sv - channel-select sequencer for the 3-to-8 decoder stage
//
// Steps the decoder select through channels 0..7 in ascending order, holding
// each channel for DWELL clocks. It runs either continuously or for one sweep,
// and is controlled by start/stop.
//
// Optional feature macro: CHAN_SCAN_MASK_EN adds the per-channel enable
// input `mask`. Without it, all eight channels are always enabled.
//
// Parameters:
//   DWELL       clocks each channel is held (1 .. 2**CNT_W)
//   CNT_W       width of the dwell counter
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       level, sampled in IDLE, begins a scan
//   stop        aborts a scan; wins over start
//   mode        0 = continuous, 1 = single sweep (captured at scan start)
//   mask        channel enables, bit i = channel i (CHAN_SCAN_MASK_EN only)
//   sel         current channel index to the decoder select
//   sel_valid   sel is a live channel (SCAN)
//   busy        scan in progress (SCAN)
//   sweep_done  one-cycle pulse after the last dwell cycle of a sweep
module chan_scan_seq #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
`ifdef CHAN_SCAN_MASK_EN
  input  logic [7:0] mask,
`endif
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       busy,
  output logic       sweep_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic             mode_q;
  logic [7:0]       en;
  logic [3:0]       first_hit;
  logic [3:0]       next_hit;

  // Lowest enabled channel with index >= from. Bit 3 flags a hit and
  // bits 2:0 give the index. A from value of 8 never hits.
  function automatic logic [3:0] pick(input logic [7:0] ens, input logic [3:0] from);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ens[i] && (i >= int'(from))) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  always_comb begin
    en = 8'hFF;
`ifdef CHAN_SCAN_MASK_EN
    en = mask;
`endif
  end

  // first_hit is where a sweep begins or wraps to. next_hit is the channel
  // after the current one; sel = 7 yields from = 8, so it never hits.
  always_comb begin
    first_hit = pick(en, 4'd0);
    next_hit  = pick(en, {1'b0, sel} + 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 3'd0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      dwell_cnt  <= '0;
      mode_q     <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          sel       <= 3'd0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
          dwell_cnt <= '0;
          if (start && !stop && first_hit[3]) begin
            state     <= SCAN;
            sel       <= first_hit[2:0];
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            mode_q    <= mode;
          end
        end

        SCAN: begin
          if (stop) begin
            state     <= IDLE;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
          end else if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end else begin
            dwell_cnt <= '0;
            if (!first_hit[3]) begin
              // Every channel was disabled by the time of the advance.
              // Abandon the sweep without reporting completion.
              state     <= IDLE;
              sel       <= 3'd0;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
            end else if (next_hit[3]) begin
              sel <= next_hit[2:0];
            end else begin
              // The highest enabled channel has finished: the sweep is complete.
              sweep_done <= 1'b1;
              if (mode_q) begin
                state     <= IDLE;
                sel       <= 3'd0;
                sel_valid <= 1'b0;
                busy      <= 1'b0;
              end else begin
                sel <= first_hit[2:0];
              end
            end
          end
        end

        default: begin
          state     <= IDLE;
          sel       <= 3'd0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_scan_seq.sv
// tb/tb_chan_scan_seq.sv - directed self-checking bench for chan_scan_seq
module tb_chan_scan_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start1;
  logic       stop;
  logic       mode;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       sweep_done;
  logic [2:0] sel1;
  logic       sel_valid1;
  logic       busy1;
  logic       sweep_done1;

  int n_cmp;
  int n_err;

  chan_scan_seq #(.DWELL(4), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
`ifdef CHAN_SCAN_MASK_EN
    .mask       (mask),
`endif
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  chan_scan_seq #(.DWELL(1), .CNT_W(8)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .stop       (stop),
    .mode       (mode),
`ifdef CHAN_SCAN_MASK_EN
    .mask       (mask),
`endif
    .sel        (sel1),
    .sel_valid  (sel_valid1),
    .busy       (busy1),
    .sweep_done (sweep_done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    stop   = 1'b0;
    mode   = 1'b0;
    mask   = 8'hFF;

    // Reset state
    #2;
    check("rst_sel", 32'(sel), 0);
    check("rst_sel_valid", 32'(sel_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(busy), 0);

    // Continuous, DWELL=4, start pulsed at edge 0
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("cont_sel_c%0d", c), 32'(sel), 32'((c - 1) / 4));
      check($sformatf("cont_valid_c%0d", c), 32'(sel_valid), 1);
      check($sformatf("cont_sd_c%0d", c), 32'(sweep_done), 0);
      tick();
    end
    check("cont_c33_sel", 32'(sel), 0);
    check("cont_c33_sd", 32'(sweep_done), 1);
    check("cont_c33_busy", 32'(busy), 1);
    for (int c = 34; c <= 64; c++) tick();
    check("cont_c64_sel", 32'(sel), 7);
    check("cont_c64_sd", 32'(sweep_done), 0);
    tick();
    check("cont_c65_sd", 32'(sweep_done), 1);
    check("cont_c65_sel", 32'(sel), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_stop_busy", 32'(busy), 0);

    // Single sweep; mode change after start must be ignored
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("single_sel_c%0d", c), 32'(sel), 32'((c - 1) / 4));
      check($sformatf("single_sd_c%0d", c), 32'(sweep_done), 0);
      tick();
    end
    check("single_c33_busy", 32'(busy), 0);
    check("single_c33_valid", 32'(sel_valid), 0);
    check("single_c33_sd", 32'(sweep_done), 1);
    check("single_c33_sel", 32'(sel), 0);
    tick();
    check("single_c34_busy", 32'(busy), 0);
    check("single_c34_sd", 32'(sweep_done), 0);
    tick();
    check("single_c35_busy", 32'(busy), 0);

    // Stop at cycle 10
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("stop_c10_sel", 32'(sel), 2);
    stop = 1'b1;
    tick();
    check("stop_c11_busy", 32'(busy), 0);
    check("stop_c11_valid", 32'(sel_valid), 0);
    check("stop_c11_sd", 32'(sweep_done), 0);
    check("stop_c11_sel", 32'(sel), 0);

    // start and stop together in IDLE
    start = 1'b1;
    tick();
    check("startstop_busy_a", 32'(busy), 0);
    tick();
    check("startstop_busy_b", 32'(busy), 0);
    stop = 1'b0;
    start = 1'b0;
    tick();

    // Single sweep with start held: restart after the sweep_done IDLE cycle
    mode  = 1'b1;
    start = 1'b1;
    tick();
    for (int c = 1; c < 33; c++) tick();
    check("hold_c33_sd", 32'(sweep_done), 1);
    check("hold_c33_valid", 32'(sel_valid), 0);
    tick();
    check("hold_c34_valid", 32'(sel_valid), 1);
    check("hold_c34_sel", 32'(sel), 0);
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    mode  = 1'b0;

    // Asynchronous reset mid-scan
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    check("arst_pre_sel", 32'(sel), 1);
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 0);
    check("arst_valid", 32'(sel_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_sd", 32'(sweep_done), 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("arst_after_busy", 32'(busy), 0);

    // DWELL=1, all channels: advance every clock
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("d1_sel_c%0d", c), 32'(sel1), 32'(c - 1));
      check($sformatf("d1_sd_c%0d", c), 32'(sweep_done1), 0);
      tick();
    end
    check("d1_c9_sel", 32'(sel1), 0);
    check("d1_c9_sd", 32'(sweep_done1), 1);
    tick();
    check("d1_c10_sd", 32'(sweep_done1), 0);
    check("d1_c10_sel", 32'(sel1), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("d1_stop_busy", 32'(busy1), 0);

`ifdef CHAN_SCAN_MASK_EN
    // Mask 1010_0100 with DWELL=4: 2,5,7 then wrap to 2
    mask  = 8'b1010_0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("mask_sel_c%0d", c), 32'(sel),
            (c <= 4) ? 32'd2 : ((c <= 8) ? 32'd5 : 32'd7));
      check($sformatf("mask_sd_c%0d", c), 32'(sweep_done), 0);
      tick();
    end
    check("mask_c13_sel", 32'(sel), 2);
    check("mask_c13_sd", 32'(sweep_done), 1);
    tick();
    mask = 8'h00;
    tick();
    tick();
    check("mask_c16_busy", 32'(busy), 1);
    tick();
    check("mask_c17_busy", 32'(busy), 0);
    check("mask_c17_sd", 32'(sweep_done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mask_zero_start_busy", 32'(busy), 0);

    // Single channel 3 with DWELL=1
    mask   = 8'b0000_1000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("one_c1_sel", 32'(sel1), 3);
    check("one_c1_sd", 32'(sweep_done1), 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("one_sel_c%0d", c), 32'(sel1), 3);
      check($sformatf("one_sd_c%0d", c), 32'(sweep_done1), 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mask = 8'hFF;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
